vga_vertical_timing: RTL and testbench
======================================

Name: vga_vertical_timing

Overview:
- Downstream stage of the VGA horizontal counter. Consumes its 10-bit horizontal pixel count and its active-low hsync.
- Produces the vertical line count, active-low vsync, the pixel display-enable, and one-cycle frame-start and line-start strobes.
- Registers hsync so every timing output leaves the block aligned to the same Clk edge.
- Feeds the pixel generator / colour output stage.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front-porch lines
- V_SYNC, 2, vsync-pulse lines
- V_BACK, 33, vertical back-porch lines
- CW, 10, counter width
- Derived constant V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).

Ports:
- Clk  in  1  system clock, rising edge
- vgaRes  in  1  synchronous, active-high reset
- horizontalCount  in  CW  pixel count from the horizontal counter (steps every 4 Clk, wraps to 0)
- hsyncIn  in  1  active-low hsync from the horizontal counter
- verticalCount  out  CW  current line, 0..V_TOTAL-1
- vsync  out  1  active-low vertical sync
- hsyncOut  out  1  hsyncIn delayed by one Clk
- videoOn  out  1  high while the pixel is visible
- frameStart  out  1  one-Clk pulse at line 0
- lineStart  out  1  one-Clk pulse at each counted line start

Behaviour:
- Clocking and reset:
  - Single clock domain; all outputs are registered.
  - Reset is sampled only on a rising Clk edge and overrides all other activity.
  - Reset values: verticalCount=0, vsync=1, hsyncOut=1, videoOn=0, frameStart=0, lineStart=0, prevH=0, state=IDLE.
- Line-end detection:
  - prevH is a register updated with horizontalCount every Clk.
  - lineEnd (combinational) = horizontalCount < prevH.
  - A backward jump counts as one line end whatever its cause (normal wrap, transient 800->0 step, or an upstream reset mid-line).
  - A held count produces no event.
- FSM states: IDLE, ACTIVE, FRONT, SYNC, BACK.
  - IDLE: waits for the first lineEnd after reset, so a partial line is never counted. On that lineEnd: verticalCount<=0, state<=ACTIVE, frameStart<=1, lineStart<=1.
  - Other states, on lineEnd: n = verticalCount+1, or 0 when verticalCount==V_TOTAL-1. Then verticalCount<=n and lineStart<=1; frameStart<=1 iff n==0.
  - State from n: ACTIVE if n<V_VISIBLE; FRONT if n<V_VISIBLE+V_FRONT; SYNC if n<V_VISIBLE+V_FRONT+V_SYNC; else BACK.
  - With the default parameters, SYNC covers lines 490-491 and line 524 wraps to 0.
  - Without lineEnd: verticalCount and state hold, and frameStart and lineStart are 0.
- Output rules:
  - vsync <= 0 iff next state is SYNC; otherwise 1.
  - videoOn <= (next state == ACTIVE) && (horizontalCount < H_VISIBLE). It is never 1 in IDLE.
  - hsyncOut <= hsyncIn.
  - Latency is one Clk from an input change to the corresponding output change. hsyncOut, videoOn and vsync are mutually aligned.
- Width and boundaries:
  - All comparisons are unsigned CW-bit. verticalCount never exceeds V_TOTAL-1.
  - Reset asserted mid-frame returns the block to IDLE on that edge. After release, counting resumes at the first lineEnd.
  - Reset coinciding with lineEnd: reset wins and the event is dropped.

Decomposition:
- Shared package vga_timing_pkg holds:
  - H_VISIBLE, H_TOTAL (800), H_SYNC_START (656), H_SYNC_END (752);
  - V_VISIBLE, V_FRONT, V_SYNC, V_BACK, V_TOTAL;
  - the vertical-state enum {IDLE, ACTIVE, FRONT, SYNC, BACK}.
- One natural sub-module: vga_line_edge_detect, holding prevH and producing the lineEnd strobe.
- The FSM, counter and output registers stay in the top module.

Test Plan:
- Reset, then a horizontal model counting 0..799 every 4 Clk, starting at 300 -> no lineStart until the wrap to 0; then verticalCount=0, frameStart=1 for 1 Clk, one Clk after the wrap.
- Run a full frame -> exactly 525 lineStart pulses and one frameStart per frame; verticalCount sequence 0..524 then 0.
- Lines 489/490/491/492 -> vsync 1/0/0/1, each change one Clk after the lineEnd cycle.
- Line 10, horizontalCount stepping 638,639,640 -> videoOn 1,1,0, one Clk late and aligned with hsyncOut; line 480, horizontalCount 0 -> videoOn=0.
- Transient horizontalCount=800 for 1 Clk, then 0 -> exactly one lineEnd; hold at 799 for 8 Clk -> none.
- vgaRes pulsed high at line 300 -> next edge: verticalCount=0, vsync=1, videoOn=0, state IDLE; counting restarts at the next wrap with frameStart=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the vertical-state type used by the
// vertical timing block and its neighbours in the video pipeline.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE    = 640;
    localparam int unsigned H_TOTAL      = 800;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_END   = 752;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } v_state_t;

endpackage

// File: rtl/vga_vertical_timing_if.sv
// Signal bundle between the horizontal counter, the vertical timing block
// and the pixel generator. The master side supplies the horizontal timing,
// the slave side (vertical timing) returns the frame-level timing.
interface vga_vertical_timing_if #(
    parameter int CW = 10
) ();

    logic [CW-1:0] horizontalCount;
    logic          hsyncIn;
    logic [CW-1:0] verticalCount;
    logic          vsync;
    logic          hsyncOut;
    logic          videoOn;
    logic          frameStart;
    logic          lineStart;

    modport master (
        output horizontalCount,
        output hsyncIn,
        input  verticalCount,
        input  vsync,
        input  hsyncOut,
        input  videoOn,
        input  frameStart,
        input  lineStart
    );

    modport slave (
        input  horizontalCount,
        input  hsyncIn,
        output verticalCount,
        output vsync,
        output hsyncOut,
        output videoOn,
        output frameStart,
        output lineStart
    );

endinterface

// File: rtl/vga_line_edge_detect.sv
// Detects the end of a horizontal line as any backward step of the
// horizontal count. A held count never produces an event.
module vga_line_edge_detect #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          srst,
    input  logic [CW-1:0] count,
    output logic          line_end
);

    logic [CW-1:0] prev_h_reg;

    // Remember last cycle's horizontal count.
    always_ff @(posedge clk) begin
        if (srst) begin
            prev_h_reg <= '0;
        end else begin
            prev_h_reg <= count;
        end
    end

    // Any wrap, glitch-return or upstream restart looks like a backward jump.
    assign line_end = (count < prev_h_reg);

endmodule

// File: rtl/vga_vertical_timing.sv
// Vertical timing stage: counts lines from the horizontal counter's wraps,
// generates vsync, display enable and frame/line strobes, and re-times
// hsync so every timing output leaves on the same clock edge.
module vga_vertical_timing #(
    parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
    parameter int          CW        = 10
) (
    input  logic                  Clk,
    input  logic                  vgaRes,
    vga_vertical_timing_if.slave  bus
);

    import vga_timing_pkg::v_state_t;
    import vga_timing_pkg::IDLE;
    import vga_timing_pkg::ACTIVE;
    import vga_timing_pkg::FRONT;
    import vga_timing_pkg::SYNC;
    import vga_timing_pkg::BACK;

    // Line numbers at which each vertical region ends (exclusive bounds).
    localparam logic [CW-1:0] ACTIVE_END = CW'(V_VISIBLE);
    localparam logic [CW-1:0] FRONT_END  = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] SYNC_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CW-1:0] LINE_LAST  = CW'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CW-1:0] H_VIS_END  = CW'(H_VISIBLE);

    v_state_t      state_reg, state_next;
    logic [CW-1:0] vcount_reg, vcount_next;
    logic [CW-1:0] n_line;
    logic          vsync_reg, vsync_next;
    logic          hsync_reg;
    logic          video_reg, video_next;
    logic          frame_reg, frame_next;
    logic          line_reg, line_next;
    logic          line_end;

    vga_line_edge_detect #(.CW(CW)) u_edge (
        .clk      (Clk),
        .srst     (vgaRes),
        .count    (bus.horizontalCount),
        .line_end (line_end)
    );

    // Candidate next line number, wrapping after the last line of the frame.
    always_comb begin
        n_line = (vcount_reg == LINE_LAST) ? '0 : vcount_reg + 1'b1;
    end

    // Next-state, line counter and strobe/output decisions.
    always_comb begin
        state_next  = state_reg;
        vcount_next = vcount_reg;
        frame_next  = 1'b0;
        line_next   = 1'b0;
        if (line_end) begin
            if (state_reg == IDLE) begin
                // First complete line after reset starts a fresh frame.
                vcount_next = '0;
                state_next  = ACTIVE;
                frame_next  = 1'b1;
                line_next   = 1'b1;
            end else begin
                vcount_next = n_line;
                line_next   = 1'b1;
                frame_next  = (n_line == '0);
                if (n_line < ACTIVE_END) begin
                    state_next = ACTIVE;
                end else if (n_line < FRONT_END) begin
                    state_next = FRONT;
                end else if (n_line < SYNC_END) begin
                    state_next = SYNC;
                end else begin
                    state_next = BACK;
                end
            end
        end
        vsync_next = (state_next != SYNC);
        video_next = (state_next == ACTIVE) && (bus.horizontalCount < H_VIS_END);
    end

    // State, counter and all timing outputs register on the same edge.
    always_ff @(posedge Clk) begin
        if (vgaRes) begin
            state_reg  <= IDLE;
            vcount_reg <= '0;
            vsync_reg  <= 1'b1;
            hsync_reg  <= 1'b1;
            video_reg  <= 1'b0;
            frame_reg  <= 1'b0;
            line_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            vcount_reg <= vcount_next;
            vsync_reg  <= vsync_next;
            hsync_reg  <= bus.hsyncIn;
            video_reg  <= video_next;
            frame_reg  <= frame_next;
            line_reg   <= line_next;
        end
    end

    assign bus.verticalCount = vcount_reg;
    assign bus.vsync         = vsync_reg;
    assign bus.hsyncOut      = hsync_reg;
    assign bus.videoOn       = video_reg;
    assign bus.frameStart    = frame_reg;
    assign bus.lineStart     = line_reg;

endmodule

// File: tb/tb_vga_vertical_timing.sv
// Randomized scoreboard bench for vga_vertical_timing. The driver pushes the
// expected registered outputs for every cycle it drives; the monitor pops and
// compares after each rising edge.
module tb_vga_vertical_timing;

    localparam int V_TOTAL = 525;

    typedef struct packed {
        logic [9:0] vc;
        logic       vs;
        logic       hso;
        logic       vo;
        logic       fs;
        logic       ls;
    } obs_t;

    logic Clk = 1'b0;
    logic vgaRes = 1'b1;

    vga_vertical_timing_if #(.CW(10)) bus ();

    vga_vertical_timing dut (
        .Clk    (Clk),
        .vgaRes (vgaRes),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    obs_t exp_q[$];
    int   pass_cnt  = 0;
    int   check_cnt = 0;
    int   cycle     = 0;

    // Reference model: frame position expressed as "lines seen since the
    // first complete line", modulo the frame length.
    bit m_started = 1'b0;
    int m_line    = 0;
    int m_prev_h  = 0;

    function automatic void model_push(input bit r, input int h, input bit hs);
        obs_t e;
        bit   le;
        e = '0;
        if (r) begin
            m_started = 1'b0;
            m_line    = 0;
            m_prev_h  = 0;
            e.vc = 10'd0; e.vs = 1'b1; e.hso = 1'b1; e.vo = 1'b0; e.fs = 1'b0; e.ls = 1'b0;
        end else begin
            le       = (h < m_prev_h);
            m_prev_h = h;
            if (le) begin
                if (!m_started) begin
                    m_started = 1'b1;
                    m_line    = 0;
                end else begin
                    m_line = (m_line + 1) % V_TOTAL;
                end
            end
            e.vc  = 10'(m_line);
            e.vs  = !(m_started && m_line >= 490 && m_line < 492);
            e.hso = hs;
            e.vo  = m_started && (m_line < 480) && (h < 640);
            e.ls  = le;
            e.fs  = le && (m_line == 0);
        end
        exp_q.push_back(e);
    endfunction

    task automatic step(input bit r, input int h, input int hold);
        bit hs;
        hs = !(h >= 656 && h < 752);
        repeat (hold) begin
            @(negedge Clk);
            vgaRes              = r;
            bus.horizontalCount = 10'(h);
            bus.hsyncIn         = hs;
            model_push(r, h, hs);
        end
    endtask

    // One compressed line: wrap to 0, visible pixels around the 640 boundary,
    // then the blanking tail ending at 799.
    task automatic run_line();
        step(1'b0, 0, $urandom_range(1, 2));
        step(1'b0, $urandom_range(1, 636), 1);
        step(1'b0, 638, $urandom_range(1, 2));
        step(1'b0, 639, 1);
        step(1'b0, 640, 1);
        step(1'b0, $urandom_range(641, 798), $urandom_range(1, 2));
        step(1'b0, 799, 1);
    endtask

    // Monitor: compare each registered output set with the scoreboard.
    bit have_fs    = 1'b0;
    int lines_since = 0;

    always @(posedge Clk) begin
        obs_t a, e;
        #1;
        cycle++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.vc  = bus.verticalCount;
            a.vs  = bus.vsync;
            a.hso = bus.hsyncOut;
            a.vo  = bus.videoOn;
            a.fs  = bus.frameStart;
            a.ls  = bus.lineStart;
            check_cnt++;
            if (a === e) begin
                pass_cnt++;
            end else begin
                $display("FAIL outputs cycle %0d: got vc=%0d vs=%b hso=%b vo=%b fs=%b ls=%b, expected vc=%0d vs=%b hso=%b vo=%b fs=%b ls=%b",
                         cycle, a.vc, a.vs, a.hso, a.vo, a.fs, a.ls,
                         e.vc, e.vs, e.hso, e.vo, e.fs, e.ls);
            end
            if (vgaRes) begin
                have_fs     = 1'b0;
                lines_since = 0;
            end else begin
                if (a.fs === 1'b1) begin
                    if (have_fs) begin
                        check_cnt++;
                        if (lines_since == V_TOTAL) begin
                            pass_cnt++;
                        end else begin
                            $display("FAIL frame_lines: got %0d lineStart pulses per frame, expected %0d",
                                     lines_since, V_TOTAL);
                        end
                    end
                    have_fs     = 1'b1;
                    lines_since = 0;
                end
                if (a.ls === 1'b1) lines_since++;
            end
        end
    end

    initial begin
        bus.horizontalCount = '0;
        bus.hsyncIn         = 1'b1;

        step(1'b1, 0, 3);
        // Partial line after reset must not be counted.
        step(1'b0, 300, 4);
        step(1'b0, 450, 4);
        step(1'b0, 799, 4);

        // Two full frames plus margin, with a transient 800 and a long hold.
        for (int i = 0; i < 2 * V_TOTAL + 5; i++) begin
            if (i == 100) begin
                step(1'b0, 0, 1);
                step(1'b0, 500, 1);
                step(1'b0, 799, 1);
                step(1'b0, 800, 1);
            end else if (i == 200) begin
                step(1'b0, 0, 1);
                step(1'b0, 799, 8);
            end else begin
                run_line();
            end
        end

        // Advance to line 300 of the current frame, then reset mid-line.
        while (m_line != 300) run_line();
        step(1'b0, 0, 1);
        step(1'b0, 400, 2);
        step(1'b1, 420, 1);
        step(1'b0, 500, 2);
        step(1'b0, 799, 2);
        for (int i = 0; i < 20; i++) run_line();

        // Reset arriving together with a line end: the event is dropped.
        step(1'b1, 0, 1);
        step(1'b0, 10, 2);
        step(1'b0, 799, 2);
        for (int i = 0; i < 12; i++) run_line();
        step(1'b0, 0, 2);

        repeat (4) @(negedge Clk);
        check_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
